// File: rtl/tristate_bus_arbiter_pkg.sv
// Shared types, defaults and helpers for the tristate bus arbiter family.
package tristate_arb_pkg;

    localparam int unsigned DEF_N_REQ      = 4;
    localparam int unsigned DEF_TURNAROUND = 1;
    localparam int unsigned DEF_MAX_HOLD   = 8;

    // Widest requester vector supported by the helpers below
    localparam int unsigned MAX_REQ = 16;
    localparam int unsigned IDX_W   = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } arb_state_t;

    function automatic logic [MAX_REQ-1:0] onehot_idx(input logic [IDX_W-1:0] idx);
        logic [MAX_REQ-1:0] vec;
        vec      = '0;
        vec[idx] = 1'b1;
        return vec;
    endfunction

endpackage

// File: rtl/tristate_bus_arbiter_if.sv
// Request/ownership signals between requesters and the tristate bus arbiter.
interface tristate_bus_arbiter_if
    import tristate_arb_pkg::*;
#(
    parameter int unsigned N_REQ = DEF_N_REQ
);
    localparam int unsigned OW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] grant;
    logic [N_REQ-1:0] drive_en;
    logic [OW-1:0]    owner;
    logic             busy;
    logic             preempt;

    modport master (input req, output grant, drive_en, owner, busy, preempt);
    modport slave  (output req, input grant, drive_en, owner, busy, preempt);

endinterface

// File: rtl/tristate_buffer.sv
// Single tristate driver onto a shared bus; high impedance when not enabled.
module tristate_buffer #(
    parameter int unsigned W = 4
) (
    input  logic         en,
    input  logic [W-1:0] d,
    output wire  [W-1:0] y
);

    assign y = en ? d : {W{1'bz}};

endmodule

// File: rtl/tristate_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after rr_ptr, wrapping.
module rr_pick #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned IW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    rr_ptr,
    output logic             valid,
    output logic [IW-1:0]    idx
);

    int unsigned j;

    always_comb begin
        valid = 1'b0;
        idx   = '0;
        j     = 0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            j = (32'(rr_ptr) + i) % N_REQ;
            if (!valid && req[IW'(j)]) begin
                valid = 1'b1;
                idx   = IW'(j);
            end
        end
    end

endmodule

// File: rtl/tristate_bus_arbiter.sv
// Round-robin owner arbiter for a shared tristate bus with turnaround gaps.
// Optional hold-timeout preemption is built when TRISTATE_ARB_TIMEOUT_EN is defined.
module tristate_bus_arbiter
    import tristate_arb_pkg::*;
#(
    parameter int unsigned N_REQ      = DEF_N_REQ,
    parameter int unsigned TURNAROUND = DEF_TURNAROUND,
    parameter int unsigned MAX_HOLD   = DEF_MAX_HOLD
) (
    input logic                   clock,
    input logic                   reset_n,
    tristate_bus_arbiter_if.master bus
);

    localparam int unsigned IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned TW = $clog2(TURNAROUND + 1);

    arb_state_t       state_q, state_n;
    logic [IW-1:0]    owner_q, owner_n;
    logic [IW-1:0]    ptr_q, ptr_n;
    logic [IW-1:0]    pick_idx;
    logic             pick_valid;
    logic [N_REQ-1:0] grant_q, grant_n;
    logic [N_REQ-1:0] own_vec;
    logic             busy_q, busy_n;
    logic [TW-1:0]    turn_q, turn_n;

`ifdef TRISTATE_ARB_TIMEOUT_EN
    localparam int unsigned HW = $clog2(MAX_HOLD + 1);
    logic [HW-1:0]    hold_q, hold_n;
    logic             preempt_q, preempt_n;
    logic             others;
`endif

    rr_pick #(.N_REQ(N_REQ), .IW(IW)) u_pick (
        .req    (bus.req),
        .rr_ptr (ptr_q),
        .valid  (pick_valid),
        .idx    (pick_idx)
    );

    assign own_vec = N_REQ'(onehot_idx(IDX_W'(owner_q)));
`ifdef TRISTATE_ARB_TIMEOUT_EN
    assign others  = |(bus.req & ~own_vec);
`endif

    // State, counters and output registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            owner_q   <= '0;
            ptr_q     <= '0;
            grant_q   <= '0;
            busy_q    <= 1'b0;
            turn_q    <= '0;
`ifdef TRISTATE_ARB_TIMEOUT_EN
            hold_q    <= '0;
            preempt_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_n;
            owner_q   <= owner_n;
            ptr_q     <= ptr_n;
            grant_q   <= grant_n;
            busy_q    <= busy_n;
            turn_q    <= turn_n;
`ifdef TRISTATE_ARB_TIMEOUT_EN
            hold_q    <= hold_n;
            preempt_q <= preempt_n;
`endif
        end
    end

    // Next state and next registered outputs; a new winner is taken from IDLE or the last TURN cycle
    always_comb begin
        state_n   = state_q;
        owner_n   = owner_q;
        ptr_n     = ptr_q;
        grant_n   = '0;
        busy_n    = 1'b0;
        turn_n    = turn_q;
`ifdef TRISTATE_ARB_TIMEOUT_EN
        hold_n    = hold_q;
        preempt_n = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_n = GRANT;
                    owner_n = pick_idx;
                    grant_n = N_REQ'(onehot_idx(IDX_W'(pick_idx)));
                    busy_n  = 1'b1;
                    ptr_n   = IW'((32'(pick_idx) + 32'd1) % N_REQ);
`ifdef TRISTATE_ARB_TIMEOUT_EN
                    hold_n  = '0;
`endif
                end
            end
            GRANT: begin
                busy_n = 1'b1;
                if (!bus.req[owner_q]) begin
                    state_n = TURN;
                    owner_n = '0;
                    turn_n  = '0;
                end
`ifdef TRISTATE_ARB_TIMEOUT_EN
                else if ((hold_q == HW'(MAX_HOLD - 1)) && others) begin
                    state_n   = TURN;
                    owner_n   = '0;
                    turn_n    = '0;
                    preempt_n = 1'b1;
                end
`endif
                else begin
                    grant_n = own_vec;
`ifdef TRISTATE_ARB_TIMEOUT_EN
                    if (hold_q != HW'(MAX_HOLD)) hold_n = hold_q + HW'(1);
`endif
                end
            end
            TURN: begin
                busy_n = 1'b1;
                if (turn_q == TW'(TURNAROUND - 1)) begin
                    if (pick_valid) begin
                        state_n = GRANT;
                        owner_n = pick_idx;
                        grant_n = N_REQ'(onehot_idx(IDX_W'(pick_idx)));
                        ptr_n   = IW'((32'(pick_idx) + 32'd1) % N_REQ);
`ifdef TRISTATE_ARB_TIMEOUT_EN
                        hold_n  = '0;
`endif
                    end else begin
                        state_n = IDLE;
                        busy_n  = 1'b0;
                    end
                end else begin
                    turn_n = turn_q + TW'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.grant    = grant_q;
    assign bus.drive_en = grant_q;
    assign bus.owner    = owner_q;
    assign bus.busy     = busy_q;
`ifdef TRISTATE_ARB_TIMEOUT_EN
    assign bus.preempt  = preempt_q;
`else
    assign bus.preempt  = 1'b0;
`endif

endmodule

// File: tb/tb_tristate_bus_arbiter.sv
// Directed bench for tristate_bus_arbiter with four tristate buffers on one bus.
module tb_tristate_bus_arbiter;

    typedef struct packed {
        logic [3:0] grant;
        logic [1:0] owner;
        logic       busy;
        logic       preempt;
    } exp_t;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] data [4];
    logic [3:0] prev_grant = '0;
    wire  [3:0] bus_data;
    exp_t       sb [$];
    int         errors = 0;
    int         checks = 0;

    tristate_bus_arbiter_if #(.N_REQ(4)) arb_if ();

    tristate_bus_arbiter #(.N_REQ(4), .TURNAROUND(1), .MAX_HOLD(8)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (arb_if)
    );

    for (genvar i = 0; i < 4; i++) begin : g_buf
        tristate_buffer #(4) u_buf (
            .en (arb_if.drive_en[i]),
            .d  (data[i]),
            .y  (bus_data)
        );
    end

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, expv);
        end
    endtask

    // Per-cycle safety: at most one enable, enables mirror grant, gap between owners, bus carries owner data
    always @(negedge clock) begin
        if (reset_n) begin
            check("onehot0", 32'($onehot0(arb_if.drive_en)), 32'd1);
            check("en_eq_grant", 32'(arb_if.drive_en), 32'(arb_if.grant));
            check("turnaround", 32'((prev_grant != 4'd0) && (arb_if.grant != 4'd0)
                                    && (prev_grant != arb_if.grant)), 32'd0);
            if (arb_if.grant != 4'd0)
                check("bus_data", 32'(bus_data), 32'(data[arb_if.owner]));
            prev_grant = arb_if.grant;
        end else begin
            prev_grant = '0;
        end
    end

    task automatic cyc(input logic [3:0] r, input logic [3:0] g, input logic [1:0] o,
                       input logic b, input logic p);
        exp_t e;
        arb_if.req = r;
        sb.push_back('{grant: g, owner: o, busy: b, preempt: p});
        @(posedge clock);
        #1;
        e = sb.pop_front();
        check("grant", 32'(arb_if.grant), 32'(e.grant));
        check("owner", 32'(arb_if.owner), 32'(e.owner));
        check("busy", 32'(arb_if.busy), 32'(e.busy));
        check("preempt", 32'(arb_if.preempt), 32'(e.preempt));
    endtask

    task automatic do_reset();
        reset_n    = 1'b0;
        arb_if.req = '0;
        repeat (2) @(posedge clock);
        #1;
        check("rst_grant", 32'(arb_if.grant), 32'd0);
        check("rst_drive_en", 32'(arb_if.drive_en), 32'd0);
        check("rst_owner", 32'(arb_if.owner), 32'd0);
        check("rst_busy", 32'(arb_if.busy), 32'd0);
        check("rst_preempt", 32'(arb_if.preempt), 32'd0);
        reset_n = 1'b1;
    endtask

    initial begin
        data[0] = 4'b1010; data[1] = 4'b0101; data[2] = 4'b0011; data[3] = 4'b1100;
        arb_if.req = '0;

        // Single requester: one-cycle latency, owner data on the bus
        do_reset();
        cyc(4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0);
        cyc(4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0);
        cyc(4'b0000, 4'b0000, 2'd0, 1'b1, 1'b0);
        cyc(4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);

        // All request, each owner releases after two cycles: strict rotation with gaps
        do_reset();
        for (int i = 0; i < 4; i++) begin
            logic [3:0] all_from;
            logic [3:0] after_rel;
            logic [3:0] gv;
            all_from  = 4'b1111 << i;
            after_rel = 4'b1111 << (i + 1);
            gv        = 4'b0001 << i;
            if (i != 0) cyc(all_from, gv, 2'(i), 1'b1, 1'b0);
            else        cyc(all_from, gv, 2'(i), 1'b1, 1'b0);
            cyc(all_from, gv, 2'(i), 1'b1, 1'b0);
            cyc(after_rel, 4'b0000, 2'd0, 1'b1, 1'b0);
        end
        cyc(4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);

        // Owner 1 holds while requester 2 waits
        cyc(4'b0110, 4'b0010, 2'd1, 1'b1, 1'b0);
`ifdef TRISTATE_ARB_TIMEOUT_EN
        for (int i = 1; i < 8; i++) cyc(4'b0110, 4'b0010, 2'd1, 1'b1, 1'b0);
        cyc(4'b0110, 4'b0000, 2'd0, 1'b1, 1'b1);
        cyc(4'b0110, 4'b0100, 2'd2, 1'b1, 1'b0);
        cyc(4'b0000, 4'b0000, 2'd0, 1'b1, 1'b0);
        cyc(4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
`else
        for (int i = 1; i < 50; i++) cyc(4'b0110, 4'b0010, 2'd1, 1'b1, 1'b0);
        cyc(4'b0000, 4'b0000, 2'd0, 1'b1, 1'b0);
        cyc(4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
`endif

        // Asynchronous reset mid-ownership clears the enables before the next edge
        cyc(4'b1000, 4'b1000, 2'd3, 1'b1, 1'b0);
        cyc(4'b1000, 4'b1000, 2'd3, 1'b1, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_drive_en", 32'(arb_if.drive_en), 32'd0);
        check("async_grant", 32'(arb_if.grant), 32'd0);
        check("async_busy", 32'(arb_if.busy), 32'd0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        cyc(4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0);
        cyc(4'b0000, 4'b0000, 2'd0, 1'b1, 1'b0);
        cyc(4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);

        // Owner 3 releases as requester 0 rises: wrap-around winner after one dead cycle
        cyc(4'b1000, 4'b1000, 2'd3, 1'b1, 1'b0);
        cyc(4'b1000, 4'b1000, 2'd3, 1'b1, 1'b0);
        cyc(4'b0001, 4'b0000, 2'd0, 1'b1, 1'b0);
        cyc(4'b1001, 4'b0001, 2'd0, 1'b1, 1'b0);
        cyc(4'b1001, 4'b0001, 2'd0, 1'b1, 1'b0);
        cyc(4'b1000, 4'b0000, 2'd0, 1'b1, 1'b0);
        cyc(4'b1000, 4'b1000, 2'd3, 1'b1, 1'b0);
        cyc(4'b0000, 4'b0000, 2'd0, 1'b1, 1'b0);
        cyc(4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);

        @(negedge clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tristate_bus_arbiter.md
# tristate_bus_arbiter

Round-robin arbiter that shares one tristate bus, built from `tristate_buffer` instances (one per requester), among `N_REQ` requesters. It grants exclusive ownership and drives each buffer's `en` from a registered one-hot enable vector. Between owners it inserts dead (turnaround) cycles so that no two buffers ever drive the bus in the same cycle. It sits beside the shared bus and is the only source of the buffer enables.

## Interface
- `N_REQ`, 4: number of requesters/buffers; legal range 2..16.
- `TURNAROUND`, 1: dead cycles with all enables low between owners; legal range 1..4.
- `MAX_HOLD`, 8: ownership cycle limit before preemption (see Configuration); legal range 2..255.
- `clock` input 1: single clock; all state changes on the rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `req` input N_REQ: per-requester bus request; level-sensitive.
- `grant` output N_REQ: registered one-hot (or zero) ownership indication.
- `drive_en` output N_REQ: registered enables to the buffers; always equal to `grant`.
- `owner` output $clog2(N_REQ): index of the current owner; 0 when the bus is not owned.
- `busy` output 1: high in GRANT and TURN.
- `preempt` output 1: one-cycle pulse when ownership is revoked by timeout.

## Operation
- The FSM has three states: IDLE, GRANT, TURN. The state encoding is `arb_state_t`.
- **IDLE** (all outputs 0):
  - If any `req` bit is set, go to GRANT.
  - The winner is the first requester set at or after `rr_ptr`, searching with wrap-around.
- **GRANT**:
  - `grant` and `drive_en` equal onehot(owner).
  - `hold_cnt` increments each cycle and saturates at `MAX_HOLD`.
  - If `req[owner]` drops, go to TURN.
  - With timeout compiled in: if `hold_cnt == MAX_HOLD-1` and any other `req` bit is set, go to TURN and pulse `preempt`.
- **TURN**:
  - `grant` and `drive_en` are all 0.
  - `turn_cnt` counts `TURNAROUND` cycles.
  - On the last cycle: if any `req` bit is set, go to GRANT (new arbitration); otherwise go to IDLE.
- **rr_ptr**: on every grant, `rr_ptr` becomes (winner+1) mod `N_REQ`. The reset value of `rr_ptr` is 0.
- **Fairness**: a requester that was preempted or released re-arbitrates at the lowest priority. A continuously asserting requester is served within (N_REQ-1)·(MAX_HOLD+TURNAROUND) cycles.
- **Safety invariant**: `drive_en` is never more than one-hot. Two different owners never appear in adjacent cycles; at least `TURNAROUND` zero cycles separate them.
- **Reset**: with `reset_n` low, state=IDLE, `grant`=`drive_en`=0, `owner`=0, `busy`=0, `preempt`=0, counters=0, `rr_ptr`=0. Assertion mid-ownership clears the enables immediately (asynchronously).

## Timing
- Latency from `req` rising in IDLE to `grant` is 1 cycle: `req` is sampled at edge k and `grant` is visible after edge k.
- Release: the owner drops `req` before edge k. After edge k, `grant` is 0 and TURN begins. The next `grant` appears after edge k+`TURNAROUND`.
- `req` bits of non-owners are don't-care during GRANT, except for the timeout check.
- Simultaneous request and release: the released owner's lower priority already applies to the next arbitration.
- A requester dropping `req` in the same cycle it would win is not granted; the sample is taken at the edge.
- `preempt` is high for exactly the first TURN cycle after a timeout.

## Configuration
- `TRISTATE_ARB_TIMEOUT_EN` defined:
  - The `hold_cnt` comparison and preemption are present.
  - `preempt` is functional.
- Not defined:
  - An owner holds the bus indefinitely while `req[owner]` stays high.
  - `hold_cnt` logic is removed.
  - `preempt` is tied to 0.
- The port list is identical in both builds.

## Structure
- Package `tristate_arb_pkg` contains:
  - `arb_state_t` (IDLE, GRANT, TURN);
  - default parameter constants;
  - function `onehot_idx` (index to one-hot vector).
- Sub-module `rr_pick`: combinational round-robin picker. Inputs: `req` and `rr_ptr`. Outputs: `valid` and winner index. This module is reused by later shared-resource arbiters.
- Top level contains: the FSM, `rr_ptr`, `hold_cnt`, `turn_cnt`, and the output registers.

## Test plan
Configuration for all scenarios: N_REQ=4, TURNAROUND=1, MAX_HOLD=8, macro defined unless noted. Each test instantiates 4 `tristate_buffer #(4)` instances on one bus.
1. Reset then `req`=0001 -> after 1 edge `grant`=0001, `owner`=0, `busy`=1. The bus carries requester 0's data (for example 4'b1010); the other buffers are at z.
2. `req`=1111 from IDLE, each owner releasing after 2 cycles -> grants in order 0001, 0010, 0100, 1000, each followed by exactly 1 cycle of `drive_en`=0000. The bus never shows x.
3. Owner 1 holds `req` with `req[2]` also set -> `grant`=0010 for 8 cycles, then `preempt`=1 and `grant`=0000 for 1 cycle, then `grant`=0100.
4. Same stimulus as scenario 3 with the macro undefined -> `grant`=0010 for 50 cycles; `preempt` stays 0.
5. `reset_n` pulled low mid-GRANT between clock edges -> `drive_en`=0000 immediately (before the next edge). After release with `req`=0100, `grant`=0100 (`rr_ptr` is back to 0).
6. Owner 3 releases in the same cycle that `req`=1001 -> TURN for 1 cycle, then `grant`=0001 (wrap-around). A per-cycle assertion checks `$onehot0(drive_en)` throughout.
